// File: rtl/aclink_pkg.sv
// Shared AC-link constants: frame geometry, tag bit and slot MSB positions, PHY state encoding.
package aclink_pkg;

  localparam int FRAME_BITS = 256;
  localparam int SYNC_BITS  = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam int TAG_CODEC_READY = 15;
  localparam int TAG_SLOT1_VALID = 14;
  localparam int TAG_SLOT2_VALID = 13;
  localparam int TAG_SLOT3_VALID = 12;
  localparam int TAG_SLOT4_VALID = 11;

  localparam int TAG_MSB   = 255;
  localparam int SLOT1_MSB = 239;
  localparam int SLOT2_MSB = 219;
  localparam int SLOT3_MSB = 199;
  localparam int SLOT4_MSB = 179;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } phy_state_e;

  // Frame bit index of a tag bit (tag bit 15 is frame MSB).
  function automatic int tag_pos(input int tag_bit);
    return TAG_MSB - 15 + tag_bit;
  endfunction

endpackage

// File: rtl/aclink_rx_deser.sv
// Negedge SDATA_IN shifter plus posedge capture of the completed frame into RX_FRAME.
// Kept apart so the dual-edge logic is isolated from the framing FSM.
module aclink_rx_deser
  import aclink_pkg::*;
(
  input  logic                  BIT_CLK,
  input  logic                  RESET,
  input  logic                  shift_en_i,
  input  logic                  capture_i,
  input  logic                  sdata_i,
  output logic [FRAME_BITS-1:0] rx_frame_o,
  output logic                  rx_valid_o,
  output logic                  codec_ready_o
);

  localparam int READY_POS = tag_pos(TAG_CODEC_READY);

  logic [FRAME_BITS-1:0] sh_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  valid_q;
  logic                  ready_q;

  // Codec launches on posedge, so sample mid-bit on negedge.
  always_ff @(negedge BIT_CLK or posedge RESET) begin
    if (RESET) begin
      sh_q <= '0;
    end else if (shift_en_i) begin
      sh_q <= {sh_q[FRAME_BITS-2:0], sdata_i};
    end
  end

  always_ff @(posedge BIT_CLK or posedge RESET) begin
    if (RESET) begin
      frame_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      valid_q <= capture_i;
      if (capture_i) begin
        frame_q <= sh_q;
        ready_q <= sh_q[READY_POS];
      end
    end
  end

  assign rx_frame_o    = frame_q;
  assign rx_valid_o    = valid_q;
  assign codec_ready_o = ready_q;

endmodule

// File: rtl/aclink_frame_phy.sv
// AC-link PHY in the BIT_CLK domain: frame counter FSM, SYNC generation and TX serialiser.
//   state    | meaning
//   ST_IDLE  | counter parked at 0, SYNC and SDATA_OUT low
//   ST_RUN   | framing continuously, counter wraps 255 -> 0
//   ST_DRAIN | ENABLE dropped; finish current frame, then idle
module aclink_frame_phy
  import aclink_pkg::*;
(
  input  logic                  BIT_CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [FRAME_BITS-1:0] TX_FRAME,
  input  logic                  TX_VALID,
  output logic                  TX_LOAD,
  output logic [FRAME_BITS-1:0] RX_FRAME,
  output logic                  RX_VALID,
  output logic                  CODEC_READY,
  output logic                  SYNC,
  output logic                  SDATA_OUT,
  input  logic                  SDATA_IN,
  output logic [CNT_W-1:0]      BIT_IDX
);

  phy_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sync_q, sync_d;
  logic                  sdata_q, sdata_d;
  logic                  rx_full_q, rx_full_d;
  logic [FRAME_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                  running;
  logic                  last_bit;
  logic                  stay_on;
  logic                  load;
  logic                  capture;

  always_ff @(posedge BIT_CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sync_q    <= 1'b0;
      sdata_q   <= 1'b0;
      rx_full_q <= 1'b0;
      tx_sh_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      sdata_q   <= sdata_d;
      rx_full_q <= rx_full_d;
      tx_sh_q   <= tx_sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    sync_d    = 1'b0;
    sdata_d   = 1'b0;
    rx_full_d = rx_full_q;
    tx_sh_d   = tx_sh_q;
    running   = (state_q != ST_IDLE);
    last_bit  = (cnt_q == CNT_W'(FRAME_BITS - 1));

    unique case (state_q)
      ST_IDLE:  if (ENABLE) state_d = ST_RUN;
      ST_RUN:   if (!ENABLE) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ENABLE)        state_d = ST_RUN;
        else if (last_bit) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    stay_on = (state_d != ST_IDLE);
    // A drain that ends here does not consume a TX frame.
    load    = (!running && ENABLE) || (running && last_bit && stay_on);

    if (!stay_on) begin
      tx_sh_d   = '0;
      rx_full_d = 1'b0;
    end else begin
      if (running) begin
        cnt_d   = cnt_q + CNT_W'(1);
        sdata_d = tx_sh_q[FRAME_BITS-1];
      end
      if (load) begin
        tx_sh_d = TX_VALID ? TX_FRAME : '0;
      end else begin
        tx_sh_d = {tx_sh_q[FRAME_BITS-2:0], 1'b0};
      end
      // Only a frame whose tag slot was fully sampled may be reported.
      if (running && last_bit) rx_full_d = 1'b1;
      sync_d = (cnt_d < CNT_W'(SYNC_BITS));
    end
  end

  assign capture = running && (cnt_q == '0) && rx_full_q;

  aclink_rx_deser u_rx_deser (
    .BIT_CLK       (BIT_CLK),
    .RESET         (RESET),
    .shift_en_i    (running),
    .capture_i     (capture),
    .sdata_i       (SDATA_IN),
    .rx_frame_o    (RX_FRAME),
    .rx_valid_o    (RX_VALID),
    .codec_ready_o (CODEC_READY)
  );

  assign TX_LOAD   = load && TX_VALID;
  assign SYNC      = sync_q;
  assign SDATA_OUT = sdata_q;
  assign BIT_IDX   = cnt_q;

endmodule

// File: tb/tb_aclink_frame_phy.sv
// Directed bench for aclink_frame_phy: start-up table, TX/RX bitstreams, drain and reset abort.
module tb_aclink_frame_phy;
  import aclink_pkg::*;

  logic                  BIT_CLK = 1'b0;
  logic                  RESET   = 1'b0;
  logic                  ENABLE  = 1'b0;
  logic [FRAME_BITS-1:0] TX_FRAME = '0;
  logic                  TX_VALID = 1'b0;
  logic                  TX_LOAD;
  logic [FRAME_BITS-1:0] RX_FRAME;
  logic                  RX_VALID;
  logic                  CODEC_READY;
  logic                  SYNC;
  logic                  SDATA_OUT;
  logic                  SDATA_IN = 1'b0;
  logic [7:0]            BIT_IDX;

  aclink_frame_phy dut (
    .BIT_CLK     (BIT_CLK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .TX_FRAME    (TX_FRAME),
    .TX_VALID    (TX_VALID),
    .TX_LOAD     (TX_LOAD),
    .RX_FRAME    (RX_FRAME),
    .RX_VALID    (RX_VALID),
    .CODEC_READY (CODEC_READY),
    .SYNC        (SYNC),
    .SDATA_OUT   (SDATA_OUT),
    .SDATA_IN    (SDATA_IN),
    .BIT_IDX     (BIT_IDX)
  );

  always #5 BIT_CLK = ~BIT_CLK;

  typedef struct {
    logic       en;
    logic       txv;
    int         n;
    logic       exp_sync;
    logic [7:0] exp_idx;
    logic       exp_load;
  } vec_t;

  vec_t         vt[10];
  int           n_pass  = 0;
  int           n_total = 0;
  logic [255:0] txf, txf2, rec;
  logic [255:0] rxd[4];
  int           loads, load_k, highs, rises, pulses;
  logic         prev;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge BIT_CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; ENABLE = 1'b0; TX_VALID = 1'b0; TX_FRAME = '0; SDATA_IN = 1'b0;
    #1;
    chk("rst_sync", SYNC, 0);
    chk("rst_sdata", SDATA_OUT, 0);
    chk("rst_idx", BIT_IDX, 0);
    chk("rst_rx_valid", RX_VALID, 0);
    chk("rst_rx_frame", RX_FRAME, 0);
    chk("rst_codec_ready", CODEC_READY, 0);
    chk("rst_tx_load", TX_LOAD, 0);
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // Records one frame from SDATA_OUT starting with the cycle after BIT_IDX=0.
  task automatic capture_frame(input int chg_k, input logic [255:0] chg_frame, input logic chg_valid,
                               output logic [255:0] r, output int nl, output int lk);
    r = '0; nl = 0; lk = -1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      r[256-k] = SDATA_OUT;
      if (TX_LOAD) begin nl++; lk = k; end
      if (k == chg_k) begin TX_FRAME = chg_frame; TX_VALID = chg_valid; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 1'b1,   3, 1'b0, 8'd0,   1'b0};
    vt[1] = '{1'b1, 1'b0,   1, 1'b1, 8'd0,   1'b0};
    vt[2] = '{1'b1, 1'b0,   1, 1'b1, 8'd1,   1'b0};
    vt[3] = '{1'b1, 1'b0,  14, 1'b1, 8'd15,  1'b0};
    vt[4] = '{1'b1, 1'b0,   1, 1'b0, 8'd16,  1'b0};
    vt[5] = '{1'b1, 1'b1, 238, 1'b0, 8'd254, 1'b0};
    vt[6] = '{1'b1, 1'b1,   1, 1'b0, 8'd255, 1'b1};
    vt[7] = '{1'b1, 1'b0,   1, 1'b1, 8'd0,   1'b0};
    vt[8] = '{1'b1, 1'b1, 255, 1'b0, 8'd255, 1'b1};
    vt[9] = '{1'b1, 1'b0,   0, 1'b0, 8'd255, 1'b0};

    txf = '0;
    txf[TAG_MSB -: 16]   = 16'hF800;
    txf[SLOT1_MSB -: 20] = 20'hA5A5A;
    txf[SLOT2_MSB -: 20] = 20'h0C3F0;
    txf[SLOT3_MSB -: 20] = 20'h12345;
    txf[SLOT4_MSB -: 20] = 20'h0F0F1;
    txf2 = {8{32'h3C96_A50F}};

    rxd[0] = '0;
    rxd[0][TAG_MSB -: 16]   = 16'h9800;
    rxd[0][SLOT3_MSB -: 20] = 20'hABCDE;
    rxd[0][SLOT4_MSB -: 20] = 20'h00F1F;
    rxd[1] = '0;
    rxd[1][tag_pos(TAG_SLOT3_VALID)] = 1'b1;
    rxd[1][tag_pos(TAG_SLOT4_VALID)] = 1'b1;
    rxd[1][SLOT3_MSB -: 20] = 20'h54321;
    rxd[1][SLOT1_MSB -: 20] = 20'h13579;
    rxd[1][tag_pos(TAG_SLOT1_VALID)] = 1'b0;
    rxd[1][tag_pos(TAG_SLOT2_VALID)] = 1'b0;
    rxd[2] = '0;
    rxd[3] = '0;

    #1;
    // Start-up / wrap table.
    do_reset();
    TX_FRAME = txf;
    for (int i = 0; i < 10; i++) begin
      ENABLE = vt[i].en;
      TX_VALID = vt[i].txv;
      #1;
      repeat (vt[i].n) tick();
      chk($sformatf("tbl%0d_sync", i), SYNC, vt[i].exp_sync);
      chk($sformatf("tbl%0d_idx", i), BIT_IDX, vt[i].exp_idx);
      chk($sformatf("tbl%0d_tx_load", i), TX_LOAD, vt[i].exp_load);
    end
    tick();
    capture_frame(0, '0, 1'b0, rec, loads, load_k);
    chk("zero_frame_sdata", rec, 0);
    chk("zero_frame_loads", loads, 0);

    // SYNC duty over three frames.
    do_reset();
    ENABLE = 1'b1;
    highs = 0; rises = 0; prev = 1'b0;
    for (int k = 0; k < 768; k++) begin
      tick();
      if (SYNC) highs++;
      if (SYNC && !prev) begin rises++; chk("sync_rise_idx", BIT_IDX, 0); end
      if (!SYNC && prev) chk("sync_fall_idx", BIT_IDX, 16);
      prev = SYNC;
    end
    chk("sync_high_count", highs, 48);
    chk("sync_rise_count", rises, 3);

    // TX serialiser.
    do_reset();
    TX_FRAME = txf; TX_VALID = 1'b1; ENABLE = 1'b1;
    #1;
    chk("tx_load_start", TX_LOAD, 1);
    tick();
    chk("tx_idx0_sdata", SDATA_OUT, 0);
    TX_VALID = 1'b0; TX_FRAME = '1;
    capture_frame(200, txf2, 1'b1, rec, loads, load_k);
    chk("tx_frame0_bits", rec, txf);
    chk("tx_frame0_loads", loads, 1);
    chk("tx_frame0_load_pos", load_k, 255);
    capture_frame(10, '1, 1'b0, rec, loads, load_k);
    chk("tx_frame1_bits", rec, txf2);
    chk("tx_frame1_loads", loads, 0);
    capture_frame(0, '0, 1'b0, rec, loads, load_k);
    chk("tx_frame2_zero", rec, 0);

    // RX deserialiser with a codec driving on posedge.
    do_reset();
    ENABLE = 1'b1;
    tick();
    pulses = 0;
    for (int k = 1; k <= 600; k++) begin
      tick();
      SDATA_IN = rxd[(k-1)/256][(256 - (k % 256)) % 256];
      if (RX_VALID) pulses++;
      if (k == 1) chk("rx_no_partial", RX_VALID, 0);
      if (k == 257) begin
        chk("rx_valid_f0", RX_VALID, 1);
        chk("rx_frame_f0", RX_FRAME, rxd[0]);
        chk("rx_slot3_f0", RX_FRAME[SLOT3_MSB -: 20], 20'hABCDE);
        chk("rx_ready_f0", CODEC_READY, 1);
      end
      if (k == 258) chk("rx_valid_width", RX_VALID, 0);
      if (k == 513) begin
        chk("rx_frame_f1", RX_FRAME, rxd[1]);
        chk("rx_ready_f1", CODEC_READY, 0);
      end
    end
    chk("rx_pulse_count", pulses, 2);

    // Drain and re-enable.
    do_reset();
    ENABLE = 1'b1;
    tick();
    repeat (100) tick();
    ENABLE = 1'b0;
    repeat (100) tick();
    chk("drain_idx200", BIT_IDX, 200);
    ENABLE = 1'b1; TX_VALID = 1'b1;
    repeat (55) tick();
    chk("reenable_tx_load", TX_LOAD, 1);
    tick();
    chk("reenable_idx", BIT_IDX, 0);
    chk("reenable_sync", SYNC, 1);
    TX_VALID = 1'b0;
    repeat (100) tick();
    ENABLE = 1'b0;
    repeat (155) tick();
    chk("drain_idx255", BIT_IDX, 255);
    tick();
    chk("drain_idle_idx", BIT_IDX, 0);
    chk("drain_idle_sync", SYNC, 0);
    repeat (5) tick();
    chk("idle_hold_idx", BIT_IDX, 0);
    chk("idle_hold_sync", SYNC, 0);
    chk("idle_hold_sdata", SDATA_OUT, 0);

    // Asynchronous reset mid-frame.
    do_reset();
    TX_FRAME = '1; TX_VALID = 1'b1; ENABLE = 1'b1; SDATA_IN = 1'b1;
    tick();
    repeat (257) tick();
    chk("pre_rst_rx_valid", RX_VALID, 1);
    chk("pre_rst_sync", SYNC, 1);
    chk("pre_rst_sdata", SDATA_OUT, 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_rx_valid", RX_VALID, 0);
    chk("async_rst_sync", SYNC, 0);
    chk("async_rst_sdata", SDATA_OUT, 0);
    chk("async_rst_codec_ready", CODEC_READY, 0);
    tick();
    RESET = 1'b0;
    tick();
    repeat (37) tick();
    chk("pre_rst37_sdata", SDATA_OUT, 1);
    #2 RESET = 1'b1;
    #1;
    chk("rst37_sdata", SDATA_OUT, 0);
    chk("rst37_idx", BIT_IDX, 0);
    tick();
    RESET = 1'b0;
    tick();
    pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (RX_VALID) pulses++;
    end
    chk("restart_no_rx_valid", pulses, 0);
    tick();
    chk("restart_rx_valid", RX_VALID, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
